jtag_scan_master: RTL and testbench
===================================

// Module: jtag_scan_master
// PURPOSE
//  On-chip TAP sequencer: turns IR/DR shift commands into TMS/TDI bit streams for the JTAG boundary-scan block, captures TDO.
//  Sits between a test host (valid/ready command/response) and the TDI/TMS/TDO pins of the scan-wrapped top level.
//  Target TAP is assumed parked in Run-Test/Idle between commands; the block always returns it there.
// PARAMETERS
//  MAX_LEN  64                        max bits per shift; covers the 3N+3 = 51-bit boundary chain at N=16
//  LEN_W    $clog2(MAX_LEN+1)         width of length fields
// PORTS
//  TCK        in   1        clock; all logic on rising edge
//  TRST       in   1        reset, synchronous, active-high
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        command accepted when cmd_valid & cmd_ready
//  cmd_op     in   2        00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE_RUN
//  cmd_len    in   LEN_W    bits to shift (IR/DR) or idle cycles (IDLE_RUN)
//  cmd_data   in   MAX_LEN  shift-in data, bit 0 shifted first
//  rsp_valid  out  1        response held until rsp_ready
//  rsp_ready  in   1        host takes response
//  rsp_data   out  MAX_LEN  captured TDO, bit 0 first-captured; bits >= len are 0
//  busy       out  1        high whenever not in IDLE
//  TMS        out  1        registered TAP mode select
//  TDI        out  1        registered TAP data in
//  TDO        in   1        TAP data out from target
// BEHAVIOUR
//  Reset (TRST=1): TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1; next state RST_SEQ. Any command in flight
//   or pending response is discarded.
//  FSM: RST_SEQ -> IDLE -> HDR -> SHIFT -> TRL -> RSP -> IDLE. IDLE_RUN: IDLE -> RUN -> RSP. RESET op: IDLE -> RST_SEQ -> RSP.
//  RST_SEQ: 5 cycles TMS=1, then 1 cycle TMS=0 (Test-Logic-Reset -> Run-Test/Idle). After power-on it goes to IDLE, after
//   a RESET op it goes to RSP.
//  IDLE: TMS=0, TDI=0, cmd_ready=1 (only state with cmd_ready=1; rsp_valid is always 0 here).
//  Outputs are registered: the first TMS bit of a sequence appears the cycle after acceptance.
//  HDR: SHIFT_IR TMS=1,1,0,0 (4 cyc); SHIFT_DR TMS=1,0,0 (3 cyc). TDI=0.
//  SHIFT: L cycles; TDI=data[i] in cycle i; TMS=0 except the last bit TMS=1 (Exit1). TDO sampled in the same cycle
//   -> rsp_data[i].
//  TRL: TMS=1 (Update), then TMS=0 (Idle); 2 cycles.
//  Traffic length: IR is L+6 cycles, DR is L+5. rsp_valid rises the cycle after the last TRL cycle.
//  IDLE_RUN: TMS=0 for len cycles, then RSP with rsp_data=0. len=0 goes directly to RSP.
//  RSP: rsp_valid=1, rsp_data stable until rsp_ready; on the handshake cycle go to IDLE, with cmd_ready=1 next cycle.
//  len=0 on SHIFT_IR/DR: no TAP traffic; RSP next cycle with data 0. len>MAX_LEN: clamp to MAX_LEN.
//  Shift counter is LEN_W bits, counts 0..L-1, no wrap. Capture register is cleared on acceptance.
//  TRST mid-shift: target is re-synchronised by RST_SEQ; partial capture is lost, no response is produced.
// STRUCTURE
//  jtag_pkg: op encoding enum, FSM state enum, IR/DR header TMS patterns and lengths, RST_SEQ length (5).
//  One sub-module: jtag_shift_buf (MAX_LEN load/shift-out of TDI, shift-in of TDO, clear).
//  FSM, phase counter and handshake logic stay in jtag_scan_master.
// TESTING (DUT = jtag_scan_master driving the N=16 scan-wrapped top; TDO looped from it)
//  Power-on TRST 2 cyc -> TMS 1,1,1,1,1,0; cmd_ready rises on cycle 7 after release; busy low.
//  SHIFT_IR len=4 data=4'b0010 -> TMS 1,1,0,0,0,0,0,1,1,0; TDI in shift = 0,1,0,0; rsp_valid 11 cycles after accept.
//  SHIFT_DR len=51 data=0 with sys pins a=16'hA5A5 b=16'h0F0F cin=1 sel=0 after SAMPLE
//   -> rsp_data[33:0] holds the pin values; bits 63:51 = 0.
//  Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data stable, cmd_ready=0, TMS=0; accept on ready.
//  len=0 SHIFT_DR and len=70 SHIFT_DR -> first: no TMS activity, rsp 0 next cycle; second: exactly 64 shift cycles.
//  TRST asserted at shift bit 20 -> reset values next cycle; RST_SEQ repeats; no rsp_valid pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG scan master: command opcodes, FSM states and the
// fixed TMS walks that move the TAP between Run-Test/Idle and the shift states.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'b00,
    OP_SHIFT_IR = 2'b01,
    OP_SHIFT_DR = 2'b10,
    OP_IDLE_RUN = 2'b11
  } jtag_op_e;

  localparam logic [2:0] ST_RST_SEQ = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_TRL     = 3'd4;
  localparam logic [2:0] ST_RUN     = 3'd5;
  localparam logic [2:0] ST_RSP     = 3'd6;

  // Header walks, bit 0 driven first: Idle->Select-DR->Select-IR->Capture-IR->Shift-IR, and the DR equivalent.
  localparam logic [3:0] HDR_IR_TMS  = 4'b0011;
  localparam logic [3:0] HDR_DR_TMS  = 4'b0001;
  localparam int         HDR_IR_LEN  = 4;
  localparam int         HDR_DR_LEN  = 3;
  localparam int         RST_SEQ_LEN = 5;

endpackage

// File: rtl/jtag_shift_buf.sv
// Holds the outgoing TDI bits of one scan transfer and collects the TDO bits
// returned by the target, placing each captured bit at its shift index.
module jtag_shift_buf #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [MAX_LEN-1:0] i_load_data,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic               i_cap_en,
  input  logic [LEN_W-1:0]   i_cap_idx,
  input  logic               i_tdo,
  output logic               o_tdi_bit,
  output logic [MAX_LEN-1:0] o_cap_data
);

  logic [MAX_LEN-1:0] r_tx;
  logic [MAX_LEN-1:0] r_cap;
  logic [MAX_LEN-1:0] w_cap_bit;

  assign w_cap_bit = {{(MAX_LEN-1){1'b0}}, i_tdo} << i_cap_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx <= '0;
    end else if (i_load) begin
      r_tx <= i_load_data;
    end else if (i_shift) begin
      r_tx <= r_tx >> 1;
    end
  end

  // Capture is cleared per command, so bits beyond the shift length stay zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cap <= '0;
    end else if (i_cap_en) begin
      r_cap <= r_cap | w_cap_bit;
    end
  end

  assign o_tdi_bit  = r_tx[0];
  assign o_cap_data = r_cap;

endmodule

// File: rtl/jtag_scan_master.sv
// TAP sequencer: turns host IR/DR shift, idle and reset commands into registered
// TMS/TDI streams, captures TDO, and always leaves the target in Run-Test/Idle.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_is_ir;
  logic             r_rst_op;
  logic             r_tms;
  logic             r_tdi;

  logic [2:0]       w_state_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_tms_nxt;
  logic             w_accept;
  jtag_op_e         w_op;
  logic [LEN_W-1:0] w_len_clamp;
  logic             w_is_ir_nxt;
  logic             w_hdr_last;
  logic             w_tx_bit;

  assign w_op        = jtag_op_e'(cmd_op);
  assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
  assign w_len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign w_is_ir_nxt = w_accept ? (w_op == OP_SHIFT_IR) : r_is_ir;
  assign w_hdr_last  = r_is_ir ? (r_cnt == LEN_W'(HDR_IR_LEN - 1))
                               : (r_cnt == LEN_W'(HDR_DR_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + LEN_W'(1);
    case (r_state)
      ST_RST_SEQ: begin
        if (r_cnt == LEN_W'(RST_SEQ_LEN)) begin
          w_state_nxt = r_rst_op ? ST_RSP : ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          case (w_op)
            OP_RESET:    w_state_nxt = ST_RST_SEQ;
            OP_IDLE_RUN: w_state_nxt = (w_len_clamp == '0) ? ST_RSP : ST_RUN;
            OP_SHIFT_IR,
            OP_SHIFT_DR: w_state_nxt = (w_len_clamp == '0) ? ST_RSP : ST_HDR;
          endcase
        end
      end
      ST_HDR: begin
        if (w_hdr_last) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == r_len - LEN_W'(1)) begin
          w_state_nxt = ST_TRL;
          w_cnt_nxt   = '0;
        end
      end
      ST_TRL: begin
        if (r_cnt == LEN_W'(1)) begin
          w_state_nxt = ST_RSP;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (r_cnt == r_len - LEN_W'(1)) begin
          w_state_nxt = ST_RSP;
          w_cnt_nxt   = '0;
        end
      end
      ST_RSP: begin
        w_cnt_nxt = '0;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_RST_SEQ;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // TMS is decoded from the upcoming state so the pin itself comes straight from a flop.
  always_comb begin
    w_tms_nxt = 1'b0;
    case (w_state_nxt)
      ST_RST_SEQ: w_tms_nxt = (w_cnt_nxt < LEN_W'(RST_SEQ_LEN));
      ST_HDR:     w_tms_nxt = w_is_ir_nxt ? HDR_IR_TMS[w_cnt_nxt[1:0]] : HDR_DR_TMS[w_cnt_nxt[1:0]];
      ST_SHIFT:   w_tms_nxt = (w_cnt_nxt == r_len - LEN_W'(1));
      ST_TRL:     w_tms_nxt = (w_cnt_nxt == '0);
      default:    w_tms_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_state  <= ST_RST_SEQ;
      r_cnt    <= '0;
      r_len    <= '0;
      r_is_ir  <= 1'b0;
      r_rst_op <= 1'b0;
      r_tms    <= 1'b1;
      r_tdi    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= (w_state_nxt == ST_SHIFT) ? w_tx_bit : 1'b0;
      if (w_accept) begin
        r_len    <= w_len_clamp;
        r_is_ir  <= w_is_ir_nxt;
        r_rst_op <= (w_op == OP_RESET);
      end
    end
  end

  jtag_shift_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift_buf (
    .i_clk       (TCK),
    .i_rst       (TRST),
    .i_load      (w_accept),
    .i_load_data (cmd_data),
    .i_shift     (w_state_nxt == ST_SHIFT),
    .i_clear     (w_accept),
    .i_cap_en    (r_state == ST_SHIFT),
    .i_cap_idx   (r_cnt),
    .i_tdo       (TDO),
    .o_tdi_bit   (w_tx_bit),
    .o_cap_data  (rsp_data)
  );

  assign TMS       = r_tms;
  assign TDI       = r_tdi;
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RSP);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed and randomized command sequences for jtag_scan_master, checked against a
// TAP-walk model built from the command rules, with TDO driven randomly every cycle.
module tb_jtag_scan_master;

  logic        TCK = 1'b0;
  logic        TRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        busy;
  logic        TMS;
  logic        TDI;
  logic        TDO = 1'b0;

  int nCmp  = 0;
  int nFail = 0;
  logic hist [0:255];

  always #5 TCK = ~TCK;

  jtag_scan_master #(.MAX_LEN(64)) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds TRST for two edges, then expects five TMS=1 cycles, one TMS=0 and ready on the seventh.
  task automatic resetSeq(input string tag);
    logic [5:0] obs;
    logic sawRsp;
    logic sawReady;
    TRST = 1'b1;
    @(negedge TCK);
    checkOutput({tag, "_rst_tms"}, TMS, 1'b1);
    checkOutput({tag, "_rst_tdi"}, TDI, 1'b0);
    checkOutput({tag, "_rst_ready"}, cmd_ready, 1'b0);
    checkOutput({tag, "_rst_rspv"}, rsp_valid, 1'b0);
    checkOutput({tag, "_rst_busy"}, busy, 1'b1);
    checkOutput({tag, "_rst_rspd"}, rsp_data, 64'd0);
    @(negedge TCK);
    TRST = 1'b0;
    sawRsp = 1'b0;
    sawReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs[i] = TMS;
      if (rsp_valid !== 1'b0) sawRsp = 1'b1;
      if (cmd_ready !== 1'b0) sawReady = 1'b1;
      @(negedge TCK);
    end
    checkOutput({tag, "_seq_tms"}, obs, 6'b011111);
    checkOutput({tag, "_seq_no_rsp"}, sawRsp, 1'b0);
    checkOutput({tag, "_seq_no_ready"}, sawReady, 1'b0);
    checkOutput({tag, "_ready_cyc7"}, cmd_ready, 1'b1);
    checkOutput({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // Issues one command, records TMS/TDI per traffic cycle, then checks the response and handshake.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input int len,
                               input logic [63:0] data, input int stall);
    int leff, n, sh, hdr, guard;
    logic [127:0] expTms, obsTms;
    logic [63:0] expTdi, obsTdi, expRsp;
    logic sawEarly, stallBad;

    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge TCK);
      guard++;
    end
    checkOutput({tag, "_ready_wait"}, cmd_ready, 1'b1);

    leff = (len > 64) ? 64 : len;
    expTms = '0; expTdi = '0; expRsp = '0;
    n = 0; sh = 0; hdr = 0;
    case (op)
      2'b00: begin n = 6; expTms = 128'b011111; end
      2'b11: n = leff;
      default: if (leff > 0) begin
        hdr = (op == 2'b01) ? 4 : 3;
        expTms[0] = 1'b1;
        if (op == 2'b01) expTms[1] = 1'b1;
        sh = hdr + 1;
        expTms[hdr + leff - 1] = 1'b1;
        expTms[hdr + leff] = 1'b1;
        n = leff + hdr + 2;
        for (int i = 0; i < leff; i++) expTdi[i] = data[i];
      end
    endcase

    cmd_valid = 1'b1; cmd_op = op; cmd_len = 7'(len); cmd_data = data;
    @(negedge TCK);
    cmd_valid = 1'b0;
    obsTms = '0; obsTdi = '0; sawEarly = 1'b0;
    for (int k = 1; k <= n; k++) begin
      obsTms[k-1] = TMS;
      if (sh > 0 && k >= sh && k < sh + leff) obsTdi[k-sh] = TDI;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) sawEarly = 1'b1;
      TDO = 1'($urandom);
      hist[k] = TDO;
      @(negedge TCK);
    end
    if (sh > 0) for (int i = 0; i < leff; i++) expRsp[i] = hist[sh + i];

    checkOutput({tag, "_tms_seq"}, obsTms, expTms);
    if (sh > 0) checkOutput({tag, "_tdi_seq"}, obsTdi, expTdi);
    checkOutput({tag, "_no_early_rsp"}, sawEarly, 1'b0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    checkOutput({tag, "_rsp_data"}, rsp_data, expRsp);
    checkOutput({tag, "_rsp_tms"}, TMS, 1'b0);

    stallBad = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== expRsp || cmd_ready !== 1'b0 || TMS !== 1'b0)
        stallBad = 1'b1;
      @(negedge TCK);
    end
    if (stall > 0) checkOutput({tag, "_stall_stable"}, stallBad, 1'b0);

    rsp_ready = 1'b1;
    @(negedge TCK);
    rsp_ready = 1'b0;
    checkOutput({tag, "_post_ready"}, cmd_ready, 1'b1);
    checkOutput({tag, "_post_rspv"}, rsp_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0] rop;
    int rlen;

    resetSeq("por");

    applyStimulus("ir4", 2'b01, 4, 64'b0010, 0);
    applyStimulus("dr51", 2'b10, 51, 64'd0, 0);
    d = {$urandom, $urandom};
    applyStimulus("bp10", 2'b10, 17, d, 10);
    applyStimulus("dr0", 2'b10, 0, d, 0);
    d = {$urandom, $urandom};
    applyStimulus("dr70", 2'b10, 70, d, 2);
    applyStimulus("run5", 2'b11, 5, 64'd0, 0);
    applyStimulus("run0", 2'b11, 0, 64'd0, 1);
    applyStimulus("rstop", 2'b00, 0, 64'd0, 0);
    d = {$urandom, $urandom};
    applyStimulus("ir64", 2'b01, 64, d, 0);

    // TRST lands on shift bit 20 of a 40-bit DR scan.
    d = {$urandom, $urandom};
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 7'd40; cmd_data = d;
    @(negedge TCK);
    cmd_valid = 1'b0;
    for (int k = 1; k < 24; k++) @(negedge TCK);
    checkOutput("mid_tdi_bit20", TDI, d[20]);
    resetSeq("mid");

    for (int t = 0; t < 12; t++) begin
      rop = 2'($urandom_range(0, 3));
      rlen = (rop == 2'b11) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 70));
      d = {$urandom, $urandom};
      applyStimulus($sformatf("rnd%0d", t), rop, rlen, d, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
